// File: rtl/pong_pkg.sv
// Shared types and constants for the pong match sequencer.
package pong_pkg;

    localparam int unsigned SCORE_W      = 14;
    localparam int unsigned SCORE_MAX    = 9999;
    localparam int unsigned SCREEN_W_DEF = 640;
    localparam int unsigned X_W          = 10;
    localparam int unsigned BALL_W_W     = 6;
    localparam int unsigned SUM_W        = 11;
    localparam int unsigned FRAME_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_POINT     = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    // Score increment that sticks at SCORE_MAX.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        if (s >= SCORE_W'(SCORE_MAX)) begin
            return SCORE_W'(SCORE_MAX);
        end
        return s + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Ball-datapath / score-display side bundle of the match sequencer.
interface pong_match_ctrl_if;
    import pong_pkg::*;

    logic                frame_tick;
    logic                start;
    logic [X_W-1:0]      ball_x;
    logic [BALL_W_W-1:0] ball_width;
    logic                ball_run;
    logic                ball_load;
    logic                serve_dir;
    logic [SCORE_W-1:0]  score_left;
    logic [SCORE_W-1:0]  score_right;
    logic                point_pulse;
    logic                game_over;
    logic                winner;

    // Producer side: frame timing, start button and ball position.
    modport master (
        output frame_tick, start, ball_x, ball_width,
        input  ball_run, ball_load, serve_dir, score_left, score_right,
               point_pulse, game_over, winner
    );

    // Sequencer side.
    modport slave (
        input  frame_tick, start, ball_x, ball_width,
        output ball_run, ball_load, serve_dir, score_left, score_right,
               point_pulse, game_over, winner
    );

endinterface

// File: rtl/pong_frame_timer.sv
// Loadable frame_tick down-counter; done_c fires on the tick that exhausts it.
module pong_frame_timer
    import pong_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               tick,
    input  logic               load,
    input  logic [FRAME_W-1:0] load_val,
    output logic               done_c
);

    logic [FRAME_W-1:0] count;

    // Reload on state entry, otherwise consume one tick per frame while enabled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && tick && (count != '0)) begin
            count <= count - FRAME_W'(1);
        end
    end

    assign done_c = en && tick && (count == FRAME_W'(1));

endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencer: serve hold, miss detection, scoring, post-point freeze, win.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned SCREEN_W     = SCREEN_W_DEF,
    parameter int unsigned WIN_SCORE    = 11,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned POINT_FRAMES = 30
) (
    input  logic              clk,
    input  logic              reset,
    pong_match_ctrl_if.slave  bus
);

    state_t             state;
    logic [SUM_W-1:0]   right_sum_c;
    logic               left_miss_c;
    logic               right_miss_c;
    logic               win_c;
    logic               timer_en_c;
    logic               timer_load_c;
    logic [FRAME_W-1:0] timer_val_c;
    logic               timer_done_c;

    // Edge tests run every clock; the 11-bit sum cannot wrap for 10-bit x + 6-bit width.
    assign right_sum_c  = {1'b0, bus.ball_x} + SUM_W'(bus.ball_width);
    assign left_miss_c  = (bus.ball_x == '0);
    assign right_miss_c = (right_sum_c >= SUM_W'(SCREEN_W));
    assign win_c        = (bus.score_left  >= SCORE_W'(WIN_SCORE)) ||
                          (bus.score_right >= SCORE_W'(WIN_SCORE));
    assign timer_en_c   = (state == ST_SERVE) || (state == ST_POINT);

    // Reload the frame timer on every transition into SERVE or POINT.
    always_comb begin
        timer_load_c = 1'b0;
        timer_val_c  = FRAME_W'(SERVE_FRAMES);
        case (state)
            ST_IDLE, ST_GAME_OVER: begin
                timer_load_c = bus.start;
            end
            ST_PLAY: begin
                timer_load_c = left_miss_c || right_miss_c;
                timer_val_c  = FRAME_W'(POINT_FRAMES);
            end
            ST_POINT: begin
                timer_load_c = timer_done_c && !win_c;
            end
            default: begin
                timer_load_c = 1'b0;
            end
        endcase
    end

    pong_frame_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .en       (timer_en_c),
        .tick     (bus.frame_tick),
        .load     (timer_load_c),
        .load_val (timer_val_c),
        .done_c   (timer_done_c)
    );

    // Match state machine with registered outputs; pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= ST_IDLE;
            bus.ball_run    <= 1'b0;
            bus.ball_load   <= 1'b0;
            bus.serve_dir   <= 1'b0;
            bus.score_left  <= '0;
            bus.score_right <= '0;
            bus.point_pulse <= 1'b0;
            bus.game_over   <= 1'b0;
            bus.winner      <= 1'b0;
        end else begin
            bus.ball_load   <= 1'b0;
            bus.point_pulse <= 1'b0;
            case (state)
                ST_IDLE, ST_GAME_OVER: begin
                    if (bus.start) begin
                        state           <= ST_SERVE;
                        bus.score_left  <= '0;
                        bus.score_right <= '0;
                        bus.ball_load   <= 1'b1;
                        bus.serve_dir   <= 1'b0;
                        bus.game_over   <= 1'b0;
                        bus.winner      <= 1'b0;
                    end
                end
                ST_SERVE: begin
                    if (timer_done_c) begin
                        state        <= ST_PLAY;
                        bus.ball_run <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    // Left edge wins a tie: only the right player is credited.
                    if (left_miss_c) begin
                        state           <= ST_POINT;
                        bus.score_right <= sat_inc(bus.score_right);
                        bus.serve_dir   <= 1'b0;
                        bus.point_pulse <= 1'b1;
                        bus.ball_run    <= 1'b0;
                    end else if (right_miss_c) begin
                        state           <= ST_POINT;
                        bus.score_left  <= sat_inc(bus.score_left);
                        bus.serve_dir   <= 1'b1;
                        bus.point_pulse <= 1'b1;
                        bus.ball_run    <= 1'b0;
                    end
                end
                ST_POINT: begin
                    if (timer_done_c) begin
                        if (win_c) begin
                            state         <= ST_GAME_OVER;
                            bus.game_over <= 1'b1;
                            bus.winner    <= (bus.score_right >= SCORE_W'(WIN_SCORE));
                        end else begin
                            state         <= ST_SERVE;
                            bus.ball_load <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl: serve, misses, tie priority, reset, win.
module tb_pong_match_ctrl;
    import pong_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   exp_l  = 0;
    int   exp_r  = 0;

    always #5 clk = ~clk;

    pong_match_ctrl_if bus ();
    pong_match_ctrl_if bus2 ();

    pong_match_ctrl #(
        .SCREEN_W(640), .WIN_SCORE(11), .SERVE_FRAMES(60), .POINT_FRAMES(30)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Narrow playfield so x==0 and an over-width sum can coincide.
    pong_match_ctrl #(
        .SCREEN_W(40), .WIN_SCORE(11), .SERVE_FRAMES(1), .POINT_FRAMES(1)
    ) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ball_centre();
        bus.ball_x     = 10'd300;
        bus.ball_width = 6'd8;
    endtask

    // Hold 60 serve ticks with the ball mid-field; ball_run must rise on the last.
    task automatic launch();
        ball_centre();
        bus.frame_tick = 1'b1;
        repeat (59) step();
        check("serve_hold_run", 32'(bus.ball_run), 32'd0);
        step();
        bus.frame_tick = 1'b0;
        check("serve_launch_run", 32'(bus.ball_run), 32'd1);
    endtask

    // 30 point ticks with the ball left parked at the edge; no extra points, one ball_load.
    task automatic finish_point();
        bus.frame_tick = 1'b1;
        repeat (29) step();
        check("point_no_load", 32'(bus.ball_load), 32'd0);
        check("point_hold_l", 32'(bus.score_left), 32'(exp_l));
        check("point_hold_r", 32'(bus.score_right), 32'(exp_r));
        step();
        bus.frame_tick = 1'b0;
        check("point_reserve_load", 32'(bus.ball_load), 32'd1);
        check("point_end_l", 32'(bus.score_left), 32'(exp_l));
        check("point_end_r", 32'(bus.score_right), 32'(exp_r));
    endtask

    initial begin
        bus.frame_tick  = 1'b0;
        bus.start       = 1'b0;
        bus2.frame_tick = 1'b0;
        bus2.start      = 1'b0;
        bus2.ball_x     = 10'd10;
        bus2.ball_width = 6'd8;
        ball_centre();

        // Reset state
        step();
        step();
        check("rst_run", 32'(bus.ball_run), 32'd0);
        check("rst_load", 32'(bus.ball_load), 32'd0);
        check("rst_sl", 32'(bus.score_left), 32'd0);
        check("rst_sr", 32'(bus.score_right), 32'd0);
        check("rst_over", 32'(bus.game_over), 32'd0);
        check("rst_winner", 32'(bus.winner), 32'd0);
        reset = 1'b1;
        step();
        check("idle_no_load", 32'(bus.ball_load), 32'd0);

        // Start from IDLE
        bus.start = 1'b1;
        step();
        check("start_load", 32'(bus.ball_load), 32'd1);
        check("start_dir", 32'(bus.serve_dir), 32'd0);
        check("start_run", 32'(bus.ball_run), 32'd0);
        step();
        check("start_ignored_serve", 32'(bus.ball_load), 32'd0);
        bus.start = 1'b0;
        launch();
        check("play_no_load", 32'(bus.ball_load), 32'd0);

        // Right miss at exact threshold 600+40=640
        bus.ball_x     = 10'd600;
        bus.ball_width = 6'd40;
        step();
        exp_l = 1;
        check("rmiss_sl", 32'(bus.score_left), 32'(exp_l));
        check("rmiss_sr", 32'(bus.score_right), 32'(exp_r));
        check("rmiss_pulse", 32'(bus.point_pulse), 32'd1);
        check("rmiss_dir", 32'(bus.serve_dir), 32'd1);
        check("rmiss_run", 32'(bus.ball_run), 32'd0);
        step();
        check("rmiss_pulse_end", 32'(bus.point_pulse), 32'd0);
        finish_point();
        step();
        check("reserve_load_once", 32'(bus.ball_load), 32'd0);
        launch();

        // Left miss with ball stalled at x=0 for 5 clocks
        bus.ball_x     = 10'd0;
        bus.ball_width = 6'd63;
        step();
        exp_r = 1;
        check("lmiss_sr", 32'(bus.score_right), 32'(exp_r));
        check("lmiss_sl", 32'(bus.score_left), 32'(exp_l));
        check("lmiss_dir", 32'(bus.serve_dir), 32'd0);
        check("lmiss_pulse", 32'(bus.point_pulse), 32'd1);
        repeat (4) step();
        check("stall_sr", 32'(bus.score_right), 32'(exp_r));
        check("stall_pulse", 32'(bus.point_pulse), 32'd0);
        finish_point();
        launch();

        // Right miss beyond threshold 630+20=650
        bus.ball_x     = 10'd630;
        bus.ball_width = 6'd20;
        step();
        exp_l = 2;
        check("rmiss2_sl", 32'(bus.score_left), 32'(exp_l));
        check("rmiss2_dir", 32'(bus.serve_dir), 32'd1);
        finish_point();
        launch();

        // Just below threshold 600+39=639 is not a miss
        bus.ball_x     = 10'd600;
        bus.ball_width = 6'd39;
        repeat (3) step();
        check("near_edge_run", 32'(bus.ball_run), 32'd1);
        check("near_edge_sl", 32'(bus.score_left), 32'(exp_l));

        // Third left-player point, then reset mid-PLAY
        bus.ball_width = 6'd40;
        step();
        exp_l = 3;
        check("rmiss3_sl", 32'(bus.score_left), 32'(exp_l));
        finish_point();
        launch();
        reset = 1'b0;
        step();
        reset = 1'b1;
        exp_l = 0;
        exp_r = 0;
        check("midrst_sl", 32'(bus.score_left), 32'd0);
        check("midrst_run", 32'(bus.ball_run), 32'd0);
        check("midrst_over", 32'(bus.game_over), 32'd0);
        check("midrst_dir", 32'(bus.serve_dir), 32'd0);
        bus.frame_tick = 1'b1;
        repeat (3) step();
        bus.frame_tick = 1'b0;
        check("midrst_idle_run", 32'(bus.ball_run), 32'd0);
        check("midrst_idle_load", 32'(bus.ball_load), 32'd0);

        // Run the right player up to 10
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("restart_load", 32'(bus.ball_load), 32'd1);
        launch();
        for (int i = 0; i < 10; i++) begin
            bus.ball_x     = 10'd0;
            bus.ball_width = 6'd8;
            step();
            exp_r++;
            check("run_up_sr", 32'(bus.score_right), 32'(exp_r));
            finish_point();
            launch();
        end

        // Winning point
        bus.ball_x = 10'd0;
        step();
        exp_r = 11;
        check("win_sr", 32'(bus.score_right), 32'd11);
        check("win_pulse", 32'(bus.point_pulse), 32'd1);
        bus.frame_tick = 1'b1;
        repeat (29) step();
        check("win_pending", 32'(bus.game_over), 32'd0);
        step();
        check("win_over", 32'(bus.game_over), 32'd1);
        check("win_winner", 32'(bus.winner), 32'd1);
        check("win_run", 32'(bus.ball_run), 32'd0);
        check("win_no_load", 32'(bus.ball_load), 32'd0);
        repeat (5) step();
        bus.frame_tick = 1'b0;
        check("over_hold_sr", 32'(bus.score_right), 32'd11);
        check("over_hold_flag", 32'(bus.game_over), 32'd1);

        // Restart from GAME_OVER
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("go_restart_sr", 32'(bus.score_right), 32'd0);
        check("go_restart_load", 32'(bus.ball_load), 32'd1);
        check("go_restart_over", 32'(bus.game_over), 32'd0);
        launch();

        // Simultaneous left and right miss on narrow playfield
        bus2.start = 1'b1;
        step();
        bus2.start      = 1'b0;
        bus2.frame_tick = 1'b1;
        step();
        bus2.frame_tick = 1'b0;
        check("tie_run", 32'(bus2.ball_run), 32'd1);
        bus2.ball_x     = 10'd0;
        bus2.ball_width = 6'd63;
        step();
        check("tie_sr", 32'(bus2.score_right), 32'd1);
        check("tie_sl", 32'(bus2.score_left), 32'd0);
        check("tie_dir", 32'(bus2.serve_dir), 32'd0);
        check("tie_pulse", 32'(bus2.point_pulse), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
